// File: rtl/seg7_scan_driver_if.sv
// Host-side bundle for the seven-segment scan driver.
// Host owns data/strobes; driver owns the display pins.
interface seg7_scan_driver_if #(
    parameter int DIGITS = 8
);
    localparam int IW = $clog2(DIGITS);

    logic                  enable;
    logic                  load;
    logic [4*DIGITS-1:0]   hex_in;
    logic [DIGITS-1:0]     point_in;
    logic [DIGITS-1:0]     blank_in;
    logic [DIGITS-1:0]     flash_in;
    logic [7:0]            seg_out;
    logic [DIGITS-1:0]     an_out;
    logic [IW-1:0]         digit_idx;

    modport master (
        output enable,
        output load,
        output hex_in,
        output point_in,
        output blank_in,
        output flash_in,
        input  seg_out,
        input  an_out,
        input  digit_idx
    );

    modport slave (
        input  enable,
        input  load,
        input  hex_in,
        input  point_in,
        input  blank_in,
        input  flash_in,
        output seg_out,
        output an_out,
        output digit_idx
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver with
// dead-time between digits and per-digit blinking.
module seg7_scan_driver #(
    parameter int DIGITS    = 8,
    parameter int SCAN_DIV  = 17,
    parameter int DEAD_CYC  = 16,
    parameter int BLINK_DIV = 25
) (
    input  logic clk,
    input  logic rst_n,
    seg7_scan_driver_if.slave bus
);
    localparam int IW = $clog2(DIGITS);

    logic [4*DIGITS-1:0]  hex_q;
    logic [DIGITS-1:0]    point_q;
    logic [DIGITS-1:0]    blank_q;
    logic [DIGITS-1:0]    flash_q;
    logic [SCAN_DIV-1:0]  presc_q, presc_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [BLINK_DIV-1:0] blink_q;
    logic [7:0]           seg_q, seg_d;
    logic [DIGITS-1:0]    an_q, an_d;
    logic [3:0]           nib;
    logic                 dark;

    function automatic logic [6:0] dec7(input logic [3:0] v);
        logic [6:0] r;
        unique case (v)
            4'h0: r = 7'h7E;
            4'h1: r = 7'h30;
            4'h2: r = 7'h6D;
            4'h3: r = 7'h79;
            4'h4: r = 7'h33;
            4'h5: r = 7'h5B;
            4'h6: r = 7'h5F;
            4'h7: r = 7'h70;
            4'h8: r = 7'h7F;
            4'h9: r = 7'h7B;
            4'hA: r = 7'h77;
            4'hB: r = 7'h1F;
            4'hC: r = 7'h4E;
            4'hD: r = 7'h3D;
            4'hE: r = 7'h4F;
            4'hF: r = 7'h47;
        endcase
        return r;
    endfunction

    always_comb begin
        presc_d = presc_q;
        idx_d   = idx_q;
        seg_d   = 8'hFF;
        an_d    = '1;
        nib     = hex_q[{idx_q, 2'b00} +: 4];
        dark    = blank_q[idx_q] |
                  (flash_q[idx_q] & blink_q[BLINK_DIV-1]);
        if (bus.enable) begin
            presc_d = presc_q + 1'b1;
            if (&presc_q) begin
                idx_d = (idx_q == IW'(DIGITS - 1)) ?
                        '0 : idx_q + 1'b1;
            end
            // Anodes stay off for the first DEAD_CYC cycles of a slot
            if (presc_q >= SCAN_DIV'(DEAD_CYC)) begin
                an_d[idx_q] = 1'b0;
                if (!dark) begin
                    seg_d = {~dec7(nib), ~point_q[idx_q]};
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hex_q   <= '0;
            point_q <= '0;
            blank_q <= '1;
            flash_q <= '0;
        end else if (bus.load) begin
            hex_q   <= bus.hex_in;
            point_q <= bus.point_in;
            blank_q <= bus.blank_in;
            flash_q <= bus.flash_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            idx_q   <= '0;
            blink_q <= '0;
            seg_q   <= 8'hFF;
            an_q    <= '1;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            blink_q <= blink_q + 1'b1;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign bus.seg_out   = seg_q;
    assign bus.an_out    = an_q;
    assign bus.digit_idx = idx_q;
endmodule
